bayer_window_stream: RTL

- Streaming front end for the demosaic filter; replaces the random-access input memory.
- Accepts a raw Bayer frame one 8-bit pixel per handshake, raster order (row 0 first, column 0 first).
- Buffers two rows internally and emits, per image pixel, a 3x3 neighbourhood window plus lateral, vertical and color tags ready for filter3x3.
- Output is a valid/ready stream, one window per pixel, in raster order of the centre pixel.

---
 rtl/pixel_pkg.sv | 25 ++
 rtl/bayer_line_buffer.sv | 19 +
 rtl/bayer_window_stream.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: pixel tag types, shared RGBA type and tag derivation for the demosaic path
package pixel_pkg;
  typedef enum logic [1:0] {RED, GREEN_BESIDE_RED, GREEN_BESIDE_BLUE, BLUE} color_t;
  typedef enum logic [1:0] {LEFT, CENTER, RIGHT} lateral_t;
  typedef enum logic [1:0] {TOP, MIDDLE, BOTTOM} vertical_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;
  typedef struct packed {
    lateral_t  lateral;
    vertical_t vertical;
    color_t    color;
  } tags_t;
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  function automatic tags_t pixel_tags(input int x, input int y, input int w, input int h);
    tags_t t;
    t.lateral  = x == 0 ? LEFT : x == w - 1 ? RIGHT : CENTER;
    t.vertical = y == 0 ? TOP : y == h - 1 ? BOTTOM : MIDDLE;
    t.color    = x[0] ? (y[0] ? BLUE : GREEN_BESIDE_RED) : (y[0] ? GREEN_BESIDE_BLUE : RED);
    return t;
  endfunction
endpackage

// File: rtl/bayer_line_buffer.sv
// bayer_line_buffer: WIDTH x 8 row store, one write port, registered read port
// Ports: clk; we/wr_addr/wr_data write; rd_addr in, rd_data out one cycle later.
module bayer_line_buffer #(
  parameter int WIDTH = 40,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bayer_window_stream.sv
// bayer_window_stream: raw Bayer pixel stream to 3x3 windows with position/colour tags
// Ports: clk, reset (sync, active-high); in_pixel/in_valid/in_ready input stream;
// out_window[row][col]/out_lateral/out_vertical/out_color/out_valid/out_ready output stream;
// frame_done pulses when the last window of a frame is accepted.
// Build option: BAYER_EDGE_MIRROR_EN mirrors out-of-image taps instead of zero filling.
module bayer_window_stream
  import pixel_pkg::*;
#(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_pixel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [1:-1][1:-1][7:0] out_window,
  output lateral_t               out_lateral,
  output vertical_t              out_vertical,
  output color_t                 out_color,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT + 1);
  state_t                 state, state_nx;
  logic [CW-1:0]          in_cnt, out_cnt;
  logic [AW-1:0]          wr_x, wr_x_nx, gen_x;
  logic [YW-1:0]          gen_y;
  logic [1:-1][7:0]       p1, p2, col;
  logic [1:-1][1:-1][7:0] win;
  logic [7:0]             top_rd, mid_rd, npx;
  logic                   slot, accept, take, last, flush_step, step, produce;
  tags_t                  tags;
  assign slot       = !out_valid || out_ready;
  assign in_ready   = !reset && state != FLUSH && slot;
  assign accept     = in_valid && in_ready;
  assign take       = out_valid && out_ready;
  assign last       = take && out_cnt == CW'(N - 1);
  assign frame_done = last;
  assign flush_step = state == FLUSH && slot && gen_y != YW'(HEIGHT);
  assign step       = accept || flush_step;
  assign produce    = flush_step || (accept && state == RUN);
  // Flush steps push zero pixels; every tap they feed lies outside the image.
  assign npx        = accept ? in_pixel : 8'h00;
  assign col        = {npx, mid_rd, top_rd};
  // Reads are addressed with the next write pointer so the registered read
  // already holds the older rows for the column completed by the next step.
  assign wr_x_nx    = (reset || last) ? '0 : !step ? wr_x : wr_x == AW'(WIDTH - 1) ? '0 : wr_x + AW'(1);
  assign tags       = pixel_tags(int'(gen_x), int'(gen_y), WIDTH, HEIGHT);
  bayer_line_buffer #(.WIDTH(WIDTH)) lb_top (
    .clk(clk), .we(step), .wr_addr(wr_x), .wr_data(mid_rd), .rd_addr(wr_x_nx), .rd_data(top_rd)
  );
  bayer_line_buffer #(.WIDTH(WIDTH)) lb_mid (
    .clk(clk), .we(step), .wr_addr(wr_x), .wr_data(npx), .rd_addr(wr_x_nx), .rd_data(mid_rd)
  );
  always_comb begin
    for (int r = -1; r <= 1; r++) win[r] = {col[r], p1[r], p2[r]};
`ifdef BAYER_EDGE_MIRROR_EN
    for (int r = -1; r <= 1; r++) begin
      win[r][-1] = gen_x == '0 ? win[r][1] : win[r][-1];
      win[r][1]  = gen_x == AW'(WIDTH - 1) ? win[r][-1] : win[r][1];
    end
    win[-1] = gen_y == '0 ? win[1] : win[-1];
    win[1]  = gen_y == YW'(HEIGHT - 1) ? win[-1] : win[1];
`else
    for (int r = -1; r <= 1; r++)
      for (int c = -1; c <= 1; c++)
        win[r][c] = ((r < 0 && gen_y == '0) || (r > 0 && gen_y == YW'(HEIGHT - 1)) ||
                     (c < 0 && gen_x == '0) || (c > 0 && gen_x == AW'(WIDTH - 1))) ? 8'h00 : win[r][c];
`endif
  end
  always_comb begin
    state_nx = state;
    state_nx = last ? FILL :
               (accept && in_cnt == CW'(N - 1)) ? FLUSH :
               (accept && state == FILL && in_cnt == CW'(WIDTH)) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    wr_x <= wr_x_nx;
    if (reset) begin
      in_cnt       <= '0;
      out_cnt      <= '0;
      gen_x        <= '0;
      gen_y        <= '0;
      p1           <= '0;
      p2           <= '0;
      out_valid    <= 1'b0;
      out_window   <= '0;
      out_lateral  <= CENTER;
      out_vertical <= MIDDLE;
      out_color    <= RED;
    end else begin
      in_cnt  <= last ? '0 : in_cnt + CW'(accept);
      out_cnt <= last ? '0 : out_cnt + CW'(take);
      if (step) begin
        p2 <= p1;
        p1 <= col;
      end
      if (produce) begin
        out_valid    <= 1'b1;
        out_window   <= win;
        out_lateral  <= tags.lateral;
        out_vertical <= tags.vertical;
        out_color    <= tags.color;
        gen_x        <= gen_x == AW'(WIDTH - 1) ? '0 : gen_x + AW'(1);
        gen_y        <= gen_x == AW'(WIDTH - 1) ? gen_y + YW'(1) : gen_y;
      end else if (take) begin
        out_valid <= 1'b0;
      end
      if (last) begin
        gen_x <= '0;
        gen_y <= '0;
      end
    end
  end
endmodule
